// File: rtl/uart_rx_pkg.sv
// UART 8N1 receiver: shared state encodings and width helpers.
// No ports; imported by every receiver file.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_DONE  = 3'd4
  } rx_state_t;

  localparam logic [2:0] ST_IDLE  = RX_IDLE;
  localparam logic [2:0] ST_START = RX_START;
  localparam logic [2:0] ST_DATA  = RX_DATA;
  localparam logic [2:0] ST_STOP  = RX_STOP;
  localparam logic [2:0] ST_DONE  = RX_DONE;

  // Counter width for values 0..n-1, never below one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte handshake between the receiver and its consumer.
// master: drives rx_data/rx_valid, reads rx_ready; slave: the reverse.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_mux_7.sv
// Next-state selector indexed by the current state code.
// Ports: sel (state), d0..d4 (candidates per state), y (next state).
import uart_rx_pkg::*;

module uart_rx_mux_7 (
  input  logic [2:0] sel,
  input  logic [2:0] d0,
  input  logic [2:0] d1,
  input  logic [2:0] d2,
  input  logic [2:0] d3,
  input  logic [2:0] d4,
  output logic [2:0] y
);
  always_comb begin
    y = ST_IDLE;
    case (sel)
      3'd0:    y = d0;
      3'd1:    y = d1;
      3'd2:    y = d2;
      3'd3:    y = d3;
      3'd4:    y = d4;
      // Unused codes recover to IDLE.
      default: y = ST_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line.
// Ports: clk, rst (async high), d (raw line), q (synchronised, resets high).
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: sync, baud timing, LSB-first shift, byte handshake.
// Ports: clk, rst, rx, bus (rx_data/rx_valid/rx_ready), frame_err, overrun, busy.
import uart_rx_pkg::*;

module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rx,
  uart_rx_if.master bus,
  output logic     frame_err,
  output logic     overrun,
  output logic     busy
);
  localparam int BW = cnt_w(CLKS_PER_BIT);
  localparam int CW = cnt_w(DATA_BITS + 1);
  localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  logic                 rx_s;
  logic [2:0]           state;
  logic [2:0]           state_nx;
  logic [BW-1:0]        baud_cnt;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS:0]   shcat;
  logic [2:0]           nx_idle;
  logic [2:0]           nx_start;
  logic [2:0]           nx_data;
  logic [2:0]           nx_stop;
  logic                 at_half;
  logic                 at_full;
  logic                 accept;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign at_half = (baud_cnt == HALF);
  assign at_full = (baud_cnt == FULL);
  assign accept  = bus.rx_valid & bus.rx_ready;
  assign busy    = (state != ST_IDLE);
  // New bit enters at the MSB; after DATA_BITS shifts bit 0 is the first one sent.
  assign shcat   = {rx_s, shreg};

  assign nx_idle  = rx_s ? ST_IDLE : ST_START;
  assign nx_start = !at_half ? ST_START :
                    rx_s     ? ST_IDLE  : ST_DATA;
  assign nx_data  = (at_full && bit_cnt == LAST) ? ST_STOP : ST_DATA;
  assign nx_stop  = !at_full ? ST_STOP :
                    rx_s     ? ST_DONE : ST_IDLE;

  uart_rx_mux_7 u_mux (
    .sel (state),
    .d0  (nx_idle),
    .d1  (nx_start),
    .d2  (nx_data),
    .d3  (nx_stop),
    .d4  (ST_IDLE),
    .y   (state_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_nx;
      baud_cnt <= (state_nx != state) ? '0 : baud_cnt + 1'b1;
      if (state == ST_START && at_half) begin
        bit_cnt <= '0;
      end
      if (state == ST_DATA && at_full) begin
        shreg   <= shcat[DATA_BITS:1];
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (accept) begin
        bus.rx_valid <= 1'b0;
      end
      if (state == ST_STOP && at_full && !rx_s) begin
        frame_err <= 1'b1;
      end
      if (state == ST_DONE) begin
        // A same-cycle accept frees the slot for the new byte.
        if (!bus.rx_valid || accept) begin
          bus.rx_data  <= shreg;
          bus.rx_valid <= 1'b1;
          frame_err    <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit, 8 data bits.
// Frames are driven bit by bit; a monitor tracks valid pulses and busy.
module tb_uart_rx_core;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic frame_err;
  logic overrun;
  logic busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int       valid_total = 0;
  int       busy_falls  = 0;
  int       rise_cyc    = 0;
  logic [7:0] cap_data  = 8'h00;
  logic     prev_valid  = 1'b0;
  logic     prev_busy   = 1'b0;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx_core #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .bus       (bus),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_valid <= bus.rx_valid;
    prev_busy  <= busy;
    if (bus.rx_valid) begin
      valid_total <= valid_total + 1;
      cap_data    <= bus.rx_data;
    end
    if (bus.rx_valid && !prev_valid) rise_cyc <= cyc;
    if (prev_busy && !busy) busy_falls <= busy_falls + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_n(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wait_n(3);
    rst = 1'b0;
    wait_n(3);
  endtask

  int v0;
  int t0;
  int b0;
  int lat;

  initial begin
    bus.rx_ready = 1'b0;
    wait_n(3);
    #1;
    check("rst_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_data", 32'(bus.rx_data), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_n(5);

    // 1: single byte, consumer ready
    bus.rx_ready = 1'b1;
    v0 = valid_total;
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    wait_n(20);
    lat = rise_cyc - t0;
    check("t1_data", 32'(cap_data), 32'hA5);
    check("t1_width", 32'(valid_total - v0), 32'd1);
    check("t1_lat_ok", 32'(lat >= 155 && lat <= 157), 32'd1);
    check("t1_ferr", 32'(frame_err), 32'd0);

    // 2: two bytes, consumer stalled
    bus.rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    wait_n(20);
    check("t2_data", 32'(bus.rx_data), 32'h3C);
    check("t2_valid", 32'(bus.rx_valid), 32'd1);
    check("t2_ovr", 32'(overrun), 32'd1);
    bus.rx_ready = 1'b1;
    wait_n(1);
    check("t2_drop", 32'(bus.rx_valid), 32'd0);
    check("t2_ovr_sticky", 32'(overrun), 32'd1);

    // 3: short glitch on an idle line
    do_reset();
    v0 = valid_total;
    b0 = busy_falls;
    rx = 1'b0;
    wait_n(5);
    rx = 1'b1;
    wait_n(30);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_seen", 32'(busy_falls - b0), 32'd1);
    check("t3_valid", 32'(valid_total - v0), 32'd0);
    check("t3_ferr", 32'(frame_err), 32'd0);

    // 4: bad stop bit, then a good byte
    v0 = valid_total;
    send_frame(8'h55, 1'b0);
    wait_n(20);
    check("t4_ferr", 32'(frame_err), 32'd1);
    check("t4_novalid", 32'(valid_total - v0), 32'd0);
    send_frame(8'h12, 1'b1);
    wait_n(20);
    check("t4_data", 32'(cap_data), 32'h12);
    check("t4_ferr_clr", 32'(frame_err), 32'd0);

    // 5: reset in the middle of bit 4
    rx = 1'b0;
    wait_n(CPB);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    wait_n(8);
    check("t5_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_valid", 32'(bus.rx_valid), 32'd0);
    check("t5_data", 32'(bus.rx_data), 32'd0);
    check("t5_ferr", 32'(frame_err), 32'd0);
    check("t5_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_n(100);
    send_frame(8'h81, 1'b1);
    wait_n(20);
    check("t5_next", 32'(cap_data), 32'h81);

    // 6: break condition
    v0 = valid_total;
    b0 = busy_falls;
    rx = 1'b0;
    wait_n(40 * CPB);
    check("t6_ferr", 32'(frame_err), 32'd1);
    check("t6_toggle", 32'(busy_falls - b0 >= 3), 32'd1);
    check("t6_novalid", 32'(valid_total - v0), 32'd0);
    rx = 1'b1;
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
